// File: rtl/fpnew_issue_ctrl.sv
// Requester-side issue/retire controller for the FPU top: allocates tags, records
// destination registers per tag and matches reordered results back onto a registered writeback port.
module fpnew_issue_ctrl #(
    parameter int NumTags = 4,
    parameter int ReqW    = 200,
    parameter int Width   = 64,
    parameter int RdW     = 5,
    parameter int TagW    = (NumTags > 1) ? $clog2(NumTags) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [ReqW-1:0]  req_data_i,
    input  logic [RdW-1:0]   req_rd_i,
    input  logic             flush_i,
    output logic             fpu_valid_o,
    input  logic             fpu_ready_i,
    output logic [ReqW-1:0]  fpu_data_o,
    output logic [TagW-1:0]  fpu_tag_o,
    output logic             fpu_flush_o,
    input  logic             fpu_out_valid_i,
    output logic             fpu_out_ready_o,
    input  logic [Width-1:0] fpu_result_i,
    input  logic [4:0]       fpu_status_i,
    input  logic [TagW-1:0]  fpu_tag_i,
    input  logic             fpu_busy_i,
    output logic             wb_valid_o,
    input  logic             wb_ready_i,
    output logic [RdW-1:0]   wb_rd_o,
    output logic [Width-1:0] wb_result_o,
    output logic [4:0]       wb_status_o,
    output logic             stale_o,
    output logic             busy_o
);

    localparam int CntW = $clog2(NumTags + 1);

    typedef enum logic {RUN, DRAIN} state_t;

    state_t             r_state;
    logic [NumTags-1:0] r_pendV;
    logic [RdW-1:0]     r_pendRd [NumTags];
    logic [CntW-1:0]    r_cnt;
    logic               r_wbValid;
    logic [RdW-1:0]     r_wbRd;
    logic [Width-1:0]   r_wbResult;
    logic [4:0]         r_wbStatus;
    logic               r_stale;

    logic               w_run;
    logic               w_full;
    logic [TagW-1:0]    w_freeTag;
    logic               w_issue;
    logic               w_outFire;
    logic               w_hit;
    logic [TagW-1:0]    w_hitIdx;
    logic [RdW-1:0]     w_hitRd;

    // Allocation and lookup both use the registered valid bits, so a tag retired
    // this cycle can never be re-issued in the same cycle.
    always_comb begin
        w_freeTag = '0;
        w_hit     = 1'b0;
        w_hitIdx  = '0;
        w_hitRd   = '0;
        for (int i = NumTags - 1; i >= 0; i--) begin
            if (!r_pendV[i]) w_freeTag = TagW'(i);
        end
        for (int i = 0; i < NumTags; i++) begin
            if (r_pendV[i] && fpu_tag_i == TagW'(i)) begin
                w_hit    = w_outFire;
                w_hitIdx = TagW'(i);
                w_hitRd  = r_pendRd[i];
            end
        end
    end

    assign w_run           = (r_state == RUN);
    assign w_full          = &r_pendV;
    assign fpu_valid_o     = req_valid_i & ~w_full & w_run & ~flush_i;
    assign req_ready_o     = fpu_valid_o & fpu_ready_i;
    assign w_issue         = req_ready_o;
    assign fpu_data_o      = req_data_i;
    assign fpu_tag_o       = w_freeTag;
    assign fpu_flush_o     = flush_i;
    assign fpu_out_ready_o = (~r_wbValid | wb_ready_i) & w_run;
    assign w_outFire       = fpu_out_valid_i & fpu_out_ready_o;

    assign wb_valid_o  = r_wbValid;
    assign wb_rd_o     = r_wbRd;
    assign wb_result_o = r_wbResult;
    assign wb_status_o = r_wbStatus;
    assign stale_o     = r_stale;
    assign busy_o      = (r_cnt != '0) | r_wbValid | (r_state == DRAIN);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= RUN;
            r_pendV    <= '0;
            for (int i = 0; i < NumTags; i++) r_pendRd[i] <= '0;
            r_cnt      <= '0;
            r_wbValid  <= 1'b0;
            r_wbRd     <= '0;
            r_wbResult <= '0;
            r_wbStatus <= '0;
            r_stale    <= 1'b0;
        end else begin
            r_stale <= w_outFire & ~w_hit;
            case (r_state)
                RUN: begin
                    if (flush_i) begin
                        r_state   <= DRAIN;
                        r_pendV   <= '0;
                        r_cnt     <= '0;
                        r_wbValid <= 1'b0;
                    end else begin
                        if (w_hit) r_pendV[w_hitIdx] <= 1'b0;
                        if (w_issue) begin
                            r_pendV[w_freeTag]  <= 1'b1;
                            r_pendRd[w_freeTag] <= req_rd_i;
                        end
                        r_cnt <= r_cnt + CntW'(w_issue) - CntW'(w_hit);
                        // Payload holds until the consumer takes it or a new result replaces it.
                        if (w_hit) begin
                            r_wbValid  <= 1'b1;
                            r_wbRd     <= w_hitRd;
                            r_wbResult <= fpu_result_i;
                            r_wbStatus <= fpu_status_i;
                        end else if (wb_ready_i) begin
                            r_wbValid <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (!fpu_busy_i && !flush_i) r_state <= RUN;
                end
                default: r_state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_fpnew_issue_ctrl.sv
// Directed self-checking bench for fpnew_issue_ctrl: issue, out-of-order retire,
// writeback backpressure, flush/drain, stale responses and reset priority.
module tb_fpnew_issue_ctrl;

    localparam int NumTags = 4;
    localparam int ReqW    = 200;
    localparam int Width   = 64;
    localparam int RdW     = 5;
    localparam int TagW    = 2;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             req_valid_i;
    logic             req_ready_o;
    logic [ReqW-1:0]  req_data_i;
    logic [RdW-1:0]   req_rd_i;
    logic             flush_i;
    logic             fpu_valid_o;
    logic             fpu_ready_i;
    logic [ReqW-1:0]  fpu_data_o;
    logic [TagW-1:0]  fpu_tag_o;
    logic             fpu_flush_o;
    logic             fpu_out_valid_i;
    logic             fpu_out_ready_o;
    logic [Width-1:0] fpu_result_i;
    logic [4:0]       fpu_status_i;
    logic [TagW-1:0]  fpu_tag_i;
    logic             fpu_busy_i;
    logic             wb_valid_o;
    logic             wb_ready_i;
    logic [RdW-1:0]   wb_rd_o;
    logic [Width-1:0] wb_result_o;
    logic [4:0]       wb_status_o;
    logic             stale_o;
    logic             busy_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    fpnew_issue_ctrl #(
        .NumTags(NumTags), .ReqW(ReqW), .Width(Width), .RdW(RdW), .TagW(TagW)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_data_i(req_data_i), .req_rd_i(req_rd_i), .flush_i(flush_i),
        .fpu_valid_o(fpu_valid_o), .fpu_ready_i(fpu_ready_i),
        .fpu_data_o(fpu_data_o), .fpu_tag_o(fpu_tag_o), .fpu_flush_o(fpu_flush_o),
        .fpu_out_valid_i(fpu_out_valid_i), .fpu_out_ready_o(fpu_out_ready_o),
        .fpu_result_i(fpu_result_i), .fpu_status_i(fpu_status_i),
        .fpu_tag_i(fpu_tag_i), .fpu_busy_i(fpu_busy_i),
        .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
        .wb_rd_o(wb_rd_o), .wb_result_o(wb_result_o), .wb_status_o(wb_status_o),
        .stale_o(stale_o), .busy_o(busy_o)
    );

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic reqValid, input logic [RdW-1:0] rd,
                                 input logic outValid, input logic [TagW-1:0] tag,
                                 input logic [Width-1:0] result, input logic [4:0] status);
        req_valid_i     = reqValid;
        req_rd_i        = rd;
        fpu_out_valid_i = outValid;
        fpu_tag_i       = tag;
        fpu_result_i    = result;
        fpu_status_i    = status;
        #1;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    localparam logic [63:0] R0 = 64'h3FF0_0000_0000_0000;
    localparam logic [63:0] R1 = 64'hC008_0000_0000_0001;
    localparam logic [63:0] R2 = 64'h4000_0000_0000_0000;
    localparam logic [63:0] R3 = 64'h7FF8_0000_0000_0000;

    initial begin
        rst_i = 1'b1;
        req_data_i = {64'hA5A5_0000_1111_2222, 72'h0, 64'h1234_5678_9ABC_DEF0};
        flush_i = 1'b0;
        fpu_ready_i = 1'b1;
        fpu_busy_i = 1'b0;
        wb_ready_i = 1'b1;
        applyStimulus(1'b0, 5'd0, 1'b0, 2'd0, 64'd0, 5'd0);
        tick();
        tick();
        rst_i = 1'b0;
        #1;
        checkOutput("rst_wb_valid", 64'(wb_valid_o), 64'd0);
        checkOutput("rst_busy", 64'(busy_o), 64'd0);
        checkOutput("rst_stale", 64'(stale_o), 64'd0);
        checkOutput("rst_out_ready", 64'(fpu_out_ready_o), 64'd1);
        checkOutput("rst_wb_rd", 64'(wb_rd_o), 64'd0);

        // Single op, result after 3 cycles
        tick();
        applyStimulus(1'b1, 5'd3, 1'b0, 2'd0, 64'd0, 5'd0);
        checkOutput("t1_valid", 64'(fpu_valid_o), 64'd1);
        checkOutput("t1_ready", 64'(req_ready_o), 64'd1);
        checkOutput("t1_tag", 64'(fpu_tag_o), 64'd0);
        checkOutput("t1_data_lo", fpu_data_o[63:0], 64'h1234_5678_9ABC_DEF0);
        checkOutput("t1_data_hi", fpu_data_o[199:136], 64'hA5A5_0000_1111_2222);
        tick();
        applyStimulus(1'b0, 5'd0, 1'b0, 2'd0, 64'd0, 5'd0);
        checkOutput("t1_busy", 64'(busy_o), 64'd1);
        tick();
        tick();
        applyStimulus(1'b0, 5'd0, 1'b1, 2'd0, R2, 5'b00001);
        checkOutput("t1_out_ready", 64'(fpu_out_ready_o), 64'd1);
        checkOutput("t1_wb_early", 64'(wb_valid_o), 64'd0);
        tick();
        applyStimulus(1'b0, 5'd0, 1'b0, 2'd0, 64'd0, 5'd0);
        checkOutput("t1_wb_valid", 64'(wb_valid_o), 64'd1);
        checkOutput("t1_wb_rd", 64'(wb_rd_o), 64'd3);
        checkOutput("t1_wb_result", wb_result_o, R2);
        checkOutput("t1_wb_status", 64'(wb_status_o), 64'd1);
        tick();
        checkOutput("t1_wb_done", 64'(wb_valid_o), 64'd0);
        checkOutput("t1_busy_done", 64'(busy_o), 64'd0);

        // Fill all four tags
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, RdW'(k + 1), 1'b0, 2'd0, 64'd0, 5'd0);
            checkOutput($sformatf("t2_tag%0d", k), 64'(fpu_tag_o), 64'(k));
            checkOutput($sformatf("t2_ready%0d", k), 64'(req_ready_o), 64'd1);
            tick();
        end
        applyStimulus(1'b1, 5'd5, 1'b0, 2'd0, 64'd0, 5'd0);
        checkOutput("t2_full_ready", 64'(req_ready_o), 64'd0);
        checkOutput("t2_full_valid", 64'(fpu_valid_o), 64'd0);

        // Out-of-order retire 2,0,3,1
        applyStimulus(1'b1, 5'd5, 1'b1, 2'd2, R2, 5'b10000);
        checkOutput("t3_full_during_retire", 64'(req_ready_o), 64'd0);
        tick();
        applyStimulus(1'b1, 5'd5, 1'b1, 2'd0, R0, 5'b01010);
        checkOutput("t3_wb_rd_a", 64'(wb_rd_o), 64'd3);
        checkOutput("t3_wb_res_a", wb_result_o, R2);
        checkOutput("t3_wb_st_a", 64'(wb_status_o), 64'b10000);
        checkOutput("t3_freed_ready", 64'(req_ready_o), 64'd1);
        checkOutput("t3_freed_tag", 64'(fpu_tag_o), 64'd2);
        req_valid_i = 1'b0;
        tick();
        applyStimulus(1'b0, 5'd0, 1'b1, 2'd3, R3, 5'b00101);
        checkOutput("t3_wb_rd_b", 64'(wb_rd_o), 64'd1);
        checkOutput("t3_wb_res_b", wb_result_o, R0);
        checkOutput("t3_wb_st_b", 64'(wb_status_o), 64'b01010);
        tick();
        applyStimulus(1'b0, 5'd0, 1'b1, 2'd1, R1, 5'b11111);
        checkOutput("t3_wb_rd_c", 64'(wb_rd_o), 64'd4);
        checkOutput("t3_wb_res_c", wb_result_o, R3);
        checkOutput("t3_wb_st_c", 64'(wb_status_o), 64'b00101);
        tick();
        applyStimulus(1'b0, 5'd0, 1'b0, 2'd0, 64'd0, 5'd0);
        checkOutput("t3_wb_rd_d", 64'(wb_rd_o), 64'd2);
        checkOutput("t3_wb_res_d", wb_result_o, R1);
        checkOutput("t3_wb_st_d", 64'(wb_status_o), 64'b11111);
        checkOutput("t3_wb_valid_d", 64'(wb_valid_o), 64'd1);
        tick();
        checkOutput("t3_busy_done", 64'(busy_o), 64'd0);

        // Writeback backpressure
        applyStimulus(1'b1, 5'd7, 1'b0, 2'd0, 64'd0, 5'd0);
        tick();
        applyStimulus(1'b1, 5'd8, 1'b0, 2'd0, 64'd0, 5'd0);
        checkOutput("t4_tag1", 64'(fpu_tag_o), 64'd1);
        tick();
        wb_ready_i = 1'b0;
        applyStimulus(1'b0, 5'd0, 1'b1, 2'd1, R1, 5'b00010);
        tick();
        applyStimulus(1'b0, 5'd0, 1'b1, 2'd0, R3, 5'b00100);
        for (int k = 0; k < 5; k++) begin
            checkOutput($sformatf("t4_out_ready%0d", k), 64'(fpu_out_ready_o), 64'd0);
            checkOutput($sformatf("t4_wb_valid%0d", k), 64'(wb_valid_o), 64'd1);
            checkOutput($sformatf("t4_wb_rd%0d", k), 64'(wb_rd_o), 64'd8);
            checkOutput($sformatf("t4_wb_res%0d", k), wb_result_o, R1);
            tick();
        end
        wb_ready_i = 1'b1;
        #1;
        checkOutput("t4_release_ready", 64'(fpu_out_ready_o), 64'd1);
        tick();
        applyStimulus(1'b0, 5'd0, 1'b0, 2'd0, 64'd0, 5'd0);
        checkOutput("t4_wb_rd2", 64'(wb_rd_o), 64'd7);
        checkOutput("t4_wb_res2", wb_result_o, R3);
        checkOutput("t4_wb_st2", 64'(wb_status_o), 64'b00100);
        checkOutput("t4_wb_valid2", 64'(wb_valid_o), 64'd1);
        tick();
        checkOutput("t4_busy_done", 64'(busy_o), 64'd0);

        // Flush with three in flight
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, RdW'(10 + k), 1'b0, 2'd0, 64'd0, 5'd0);
            tick();
        end
        flush_i = 1'b1;
        fpu_busy_i = 1'b1;
        applyStimulus(1'b1, 5'd13, 1'b0, 2'd0, 64'd0, 5'd0);
        checkOutput("t5_flush_out", 64'(fpu_flush_o), 64'd1);
        checkOutput("t5_flush_valid", 64'(fpu_valid_o), 64'd0);
        checkOutput("t5_flush_ready", 64'(req_ready_o), 64'd0);
        tick();
        flush_i = 1'b0;
        #1;
        checkOutput("t5_flush_pulse", 64'(fpu_flush_o), 64'd0);
        checkOutput("t5_wb_valid", 64'(wb_valid_o), 64'd0);
        checkOutput("t5_drain_ready", 64'(req_ready_o), 64'd0);
        checkOutput("t5_drain_out_ready", 64'(fpu_out_ready_o), 64'd0);
        checkOutput("t5_drain_busy", 64'(busy_o), 64'd1);
        tick();
        checkOutput("t5_drain_ready2", 64'(req_ready_o), 64'd0);
        fpu_busy_i = 1'b0;
        #1;
        checkOutput("t5_drain_ready3", 64'(req_ready_o), 64'd0);
        tick();
        checkOutput("t5_run_ready", 64'(req_ready_o), 64'd1);
        checkOutput("t5_run_tag", 64'(fpu_tag_o), 64'd0);
        tick();
        applyStimulus(1'b0, 5'd0, 1'b0, 2'd0, 64'd0, 5'd0);

        // Stray tag, then same-cycle issue and retire
        applyStimulus(1'b0, 5'd0, 1'b1, 2'd1, R0, 5'b00000);
        tick();
        applyStimulus(1'b0, 5'd0, 1'b0, 2'd0, 64'd0, 5'd0);
        checkOutput("t6_stale", 64'(stale_o), 64'd1);
        checkOutput("t6_stale_no_wb", 64'(wb_valid_o), 64'd0);
        tick();
        checkOutput("t6_stale_pulse", 64'(stale_o), 64'd0);
        applyStimulus(1'b1, 5'd14, 1'b1, 2'd0, R2, 5'b01000);
        checkOutput("t6_issue_tag", 64'(fpu_tag_o), 64'd1);
        checkOutput("t6_issue_ready", 64'(req_ready_o), 64'd1);
        tick();
        applyStimulus(1'b0, 5'd0, 1'b0, 2'd0, 64'd0, 5'd0);
        checkOutput("t6_wb_rd", 64'(wb_rd_o), 64'd13);
        checkOutput("t6_wb_res", wb_result_o, R2);
        checkOutput("t6_stale_hit", 64'(stale_o), 64'd0);
        tick();
        checkOutput("t6_cnt_held", 64'(busy_o), 64'd1);
        checkOutput("t6_free_tag", 64'(fpu_tag_o), 64'd0);
        applyStimulus(1'b0, 5'd0, 1'b1, 2'd1, R1, 5'b00011);
        tick();
        applyStimulus(1'b0, 5'd0, 1'b0, 2'd0, 64'd0, 5'd0);
        checkOutput("t6_wb_rd2", 64'(wb_rd_o), 64'd14);
        tick();
        checkOutput("t6_busy_done", 64'(busy_o), 64'd0);

        // Reset beats a flush and an in-flight op
        applyStimulus(1'b1, 5'd9, 1'b0, 2'd0, 64'd0, 5'd0);
        tick();
        flush_i = 1'b1;
        rst_i = 1'b1;
        applyStimulus(1'b0, 5'd0, 1'b0, 2'd0, 64'd0, 5'd0);
        tick();
        flush_i = 1'b0;
        rst_i = 1'b0;
        #1;
        checkOutput("t7_busy", 64'(busy_o), 64'd0);
        req_valid_i = 1'b1;
        #1;
        checkOutput("t7_run_ready", 64'(req_ready_o), 64'd1);
        checkOutput("t7_tag", 64'(fpu_tag_o), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
